// File: rtl/rf_pkg.sv
// Shared widths, types and writeback-source encoding for the register-file scheduler.
package rf_pkg;
  localparam int REGISTER_ADDRESS_WIDTH = 5;
  localparam int REGISTER_ADDRESS_DEPTH = 32;
  localparam int DATA_WIDTH             = 32;

  typedef logic [REGISTER_ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]             reg_data_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;
endpackage

// File: rtl/rf_wb_rr_arbiter.sv
// Two-way round-robin writeback arbiter (ALU vs LSU), one grant per cycle.
// Grants are combinational from the valids and the last-grant pointer.
module rf_wb_rr_arbiter
  import rf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_grant,
  output logic lsu_grant
);

  wb_src_e last_q, last_d;

  // Grant the sole requester, or on a tie the one not granted last.
  always_comb begin
    alu_grant = alu_valid && (!lsu_valid || (last_q == WB_LSU));
    lsu_grant = lsu_valid && (!alu_valid || (last_q == WB_ALU));
    last_d    = last_q;
    if (alu_grant)      last_d = WB_ALU;
    else if (lsu_grant) last_d = WB_LSU;
  end

  // Pointer starts at LSU so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= WB_LSU;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/rf_sched.sv
// Issue scoreboard (RAW/WAW stall) plus arbitrated, registered register-file
// write port fed by the ALU and LSU writeback channels.
module rf_sched #(
  parameter int REGISTER_ADDRESS_WIDTH = rf_pkg::REGISTER_ADDRESS_WIDTH,
  parameter int REGISTER_ADDRESS_DEPTH = rf_pkg::REGISTER_ADDRESS_DEPTH,
  parameter int DATA_WIDTH             = rf_pkg::DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              issue_valid,
  output logic                              issue_ready,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] issue_rs1,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] issue_rs2,
  input  logic                              issue_use_rs1,
  input  logic                              issue_use_rs2,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] issue_rd,
  input  logic                              issue_rd_we,
  input  logic                              alu_wb_valid,
  output logic                              alu_wb_ready,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] alu_wb_rd,
  input  logic [DATA_WIDTH-1:0]             alu_wb_data,
  input  logic                              lsu_wb_valid,
  output logic                              lsu_wb_ready,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0]             lsu_wb_data,
  output logic                              rf_we,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] rf_address3,
  output logic [DATA_WIDTH-1:0]             rf_write_data,
  output logic [REGISTER_ADDRESS_DEPTH-1:0] busy_map,
  output logic                              wb_err
);

  logic [REGISTER_ADDRESS_DEPTH-1:0] busy_map_q, busy_map_d;
  logic                              rf_we_q, rf_we_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0] rf_address3_q, rf_address3_d;
  logic [DATA_WIDTH-1:0]             rf_write_data_q, rf_write_data_d;
  logic                              wb_err_q, wb_err_d;

  logic                              alu_grant, lsu_grant;
  logic                              wb_fire, issue_fire;
  logic [REGISTER_ADDRESS_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]             wb_data;

  rf_wb_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_wb_valid),
    .lsu_valid (lsu_wb_valid),
    .alu_grant (alu_grant),
    .lsu_grant (lsu_grant)
  );

  // Stall when any used source or the destination has a write in flight.
  always_comb begin
    issue_ready = !((issue_use_rs1 && busy_map_q[issue_rs1]) ||
                    (issue_use_rs2 && busy_map_q[issue_rs2]) ||
                    (issue_rd_we   && busy_map_q[issue_rd]));
  end

  // Select the granted writeback and compute scoreboard / write-port next state.
  always_comb begin
    alu_wb_ready = alu_grant;
    lsu_wb_ready = lsu_grant;
    wb_fire      = alu_grant || lsu_grant;
    wb_rd        = alu_grant ? alu_wb_rd   : lsu_wb_rd;
    wb_data      = alu_grant ? alu_wb_data : lsu_wb_data;
    issue_fire   = issue_valid && issue_ready;

    // Clear is applied before set so a same-edge collision leaves the bit set.
    busy_map_d = busy_map_q;
    if (rf_we_q) busy_map_d[rf_address3_q] = 1'b0;
    if (issue_fire && issue_rd_we && (issue_rd != '0)) busy_map_d[issue_rd] = 1'b1;
    busy_map_d[0] = 1'b0;

    // x0 writebacks complete the handshake but never reach the register file.
    rf_we_d         = wb_fire && (wb_rd != '0);
    rf_address3_d   = rf_we_d ? wb_rd   : rf_address3_q;
    rf_write_data_d = rf_we_d ? wb_data : rf_write_data_q;

    wb_err_d = wb_err_q || (rf_we_d && !busy_map_q[wb_rd]);
  end

  // State registers with synchronous reset; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_map_q      <= '0;
      rf_we_q         <= 1'b0;
      rf_address3_q   <= '0;
      rf_write_data_q <= '0;
      wb_err_q        <= 1'b0;
    end else begin
      busy_map_q      <= busy_map_d;
      rf_we_q         <= rf_we_d;
      rf_address3_q   <= rf_address3_d;
      rf_write_data_q <= rf_write_data_d;
      wb_err_q        <= wb_err_d;
    end
  end

  assign busy_map      = busy_map_q;
  assign rf_we         = rf_we_q;
  assign rf_address3   = rf_address3_q;
  assign rf_write_data = rf_write_data_q;
  assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_rf_sched.sv
// Bench for rf_sched: hazard vector table, hand-written corner sequences, and a
// scoreboard queue that expects each granted write on the port one cycle later.
module tb_rf_sched;

  logic        clk, reset;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs1, issue_use_rs2, issue_rd_we;
  logic        alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  alu_wb_rd, lsu_wb_rd;
  logic [31:0] alu_wb_data, lsu_wb_data;
  logic        rf_we;
  logic [4:0]  rf_address3;
  logic [31:0] rf_write_data;
  logic [31:0] busy_map;
  logic        wb_err;

  rf_sched dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .rf_we(rf_we), .rf_address3(rf_address3), .rf_write_data(rf_write_data),
    .busy_map(busy_map), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rd;  logic we;
    logic       ready;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0;
    issue_use_rs2 = 0; issue_rd = 0; issue_rd_we = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
  endtask

  task automatic iss(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic we);
    issue_valid = v; issue_rs1 = r1; issue_use_rs1 = u1;
    issue_rs2 = r2; issue_use_rs2 = u2; issue_rd = rd; issue_rd_we = we;
  endtask

  // g: expected grant, 0 none, 1 ALU, 2 LSU. Granted non-x0 writes outside
  // reset are queued for the write port one cycle later.
  task automatic wb(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                    input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                    input int g);
    exp_t e;
    alu_wb_valid = av; alu_wb_rd = ar; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_rd = lr; lsu_wb_data = ld;
    #1;
    chk("alu_wb_ready", alu_wb_ready, (g == 1));
    chk("lsu_wb_ready", lsu_wb_ready, (g == 2));
    if (!reset) begin
      e.due = cyc + 1;
      if (g == 1 && ar != 0) begin e.rd = ar; e.data = ad; sb.push_back(e); end
      if (g == 2 && lr != 0) begin e.rd = lr; e.data = ld; sb.push_back(e); end
    end
  endtask

  // Write-port monitor: each queued write must appear exactly in its cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("wb_lost", 1'b1, 1'b0);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("sb_rf_we", rf_we, 1'b1);
        chk("sb_rf_address3", rf_address3, sb[0].rd);
        chk("sb_rf_write_data", rf_write_data, sb[0].data);
        void'(sb.pop_front());
      end else begin
        chk("sb_rf_we_idle", rf_we, 1'b0);
      end
    end
  end

  initial begin
    // busy regs for the table: 5 and 17
    tbl[0] = '{5'd5,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
    tbl[1] = '{5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1};
    tbl[2] = '{5'd0,  1'b0, 5'd17, 1'b1, 5'd0,  1'b0, 1'b0};
    tbl[3] = '{5'd6,  1'b1, 5'd17, 1'b0, 5'd0,  1'b0, 1'b1};
    tbl[4] = '{5'd0,  1'b0, 5'd0,  1'b0, 5'd5,  1'b1, 1'b0};
    tbl[5] = '{5'd0,  1'b0, 5'd0,  1'b0, 5'd5,  1'b0, 1'b1};
    tbl[6] = '{5'd4,  1'b1, 5'd6,  1'b1, 5'd18, 1'b1, 1'b1};
    tbl[7] = '{5'd0,  1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 1'b1};
    tbl[8] = '{5'd1,  1'b1, 5'd0,  1'b0, 5'd17, 1'b1, 1'b0};
    tbl[9] = '{5'd16, 1'b1, 5'd18, 1'b1, 5'd0,  1'b0, 1'b1};

    reset = 1'b1;
    idle();
    repeat (2) step();
    mon_en = 1'b1;
    chk("rst_busy_map", busy_map, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_address3", rf_address3, 0);
    chk("rst_rf_write_data", rf_write_data, 0);
    chk("rst_wb_err", wb_err, 0);
    wb(1, 5'd3, 32'h3, 1, 5'd4, 32'h4, 1);   // readies live during reset
    step();
    idle(); reset = 1'b0;
    step();

    // Hazard table
    iss(1, 0, 0, 0, 0, 5'd5, 1); #1 chk("iss5_ready", issue_ready, 1); step();
    iss(1, 0, 0, 0, 0, 5'd17, 1); #1 chk("iss17_ready", issue_ready, 1); step();
    idle(); #1;
    chk("busy_5_17", busy_map, 32'h0002_0020);
    for (int i = 0; i < 10; i++) begin
      iss(0, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd, tbl[i].we);
      #1 chk($sformatf("vec%0d_ready", i), issue_ready, tbl[i].ready);
      step();
    end

    // RAW on x5 held until the write-port cycle has ended
    iss(1, 5'd5, 1, 0, 0, 0, 0);
    #1 chk("raw_stall", issue_ready, 0);
    wb(1, 5'd5, 32'h0000_0055, 0, 0, 0, 1);
    step();
    wb(0, 0, 0, 0, 0, 0, 0);
    chk("raw_stall_we_cycle", issue_ready, 0);
    chk("raw_we_cycle_rf_we", rf_we, 1);
    step();
    chk("raw_busy5_clear", busy_map[5], 0);
    chk("raw_release", issue_ready, 1);
    step();
    idle();
    wb(0, 0, 0, 1, 5'd17, 32'h0000_1717, 2);
    step(); idle(); step();
    chk("busy_all_clear", busy_map, 0);

    // x0 issue and writeback
    iss(1, 0, 0, 0, 0, 5'd0, 1);
    #1 chk("x0_issue_ready", issue_ready, 1);
    step(); idle();
    chk("x0_issue_busy", busy_map, 0);
    wb(1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 1);
    step(); idle();
    chk("x0_wb_rf_we", rf_we, 0);
    chk("x0_wb_busy", busy_map, 0);
    chk("x0_wb_err", wb_err, 0);
    step();

    // Writeback to non-busy x7
    wb(0, 0, 0, 1, 5'd7, 32'h7777_0007, 2);
    step(); idle();
    chk("err_rf_we", rf_we, 1);
    chk("err_rf_address3", rf_address3, 7);
    chk("err_set", wb_err, 1);
    repeat (3) step();
    chk("err_sticky", wb_err, 1);

    // Tie for four cycles: ALU, LSU, ALU, LSU
    for (int i = 0; i < 4; i++) begin
      wb(1, 5'd3, 32'h3000 + i, 1, 5'd4, 32'h4000 + i, (i % 2 == 0) ? 1 : 2);
      step();
    end
    idle(); step();

    // Same-edge clear/set of x12: set wins
    wb(1, 5'd12, 32'h0000_000C, 0, 0, 0, 1);
    step(); idle();
    iss(1, 0, 0, 0, 0, 5'd12, 1);
    #1 chk("coll_issue_ready", issue_ready, 1);
    chk("coll_rf_address3", rf_address3, 12);
    step(); idle();
    chk("coll_busy12", busy_map, 32'h0000_1000);
    wb(1, 5'd12, 32'h0000_00CC, 0, 0, 0, 1);
    step(); idle(); step();
    chk("coll_busy_cleared", busy_map, 0);

    // Reset after a writeback fire, and writeback dropped by reset
    iss(1, 0, 0, 0, 0, 5'd10, 1); step(); idle();
    chk("pre_rst_busy10", busy_map, 32'h0000_0400);
    wb(1, 5'd9, 32'h0000_0009, 0, 0, 0, 1);
    step(); idle();
    reset = 1'b1;
    chk("pre_rst_rf_we", rf_we, 1);
    wb(1, 5'd9, 32'h0000_0909, 0, 0, 0, 1);
    step();
    chk("post_rst_rf_we", rf_we, 0);
    chk("post_rst_busy", busy_map, 0);
    chk("post_rst_err", wb_err, 0);
    chk("post_rst_addr", rf_address3, 0);
    chk("post_rst_data", rf_write_data, 0);
    wb(1, 5'd9, 32'h0000_0999, 1, 5'd4, 32'h0000_0444, 1);
    step();
    chk("rst_hold_rf_we", rf_we, 0);
    reset = 1'b0;
    wb(1, 5'd9, 32'h0000_0099, 1, 5'd4, 32'h0000_0044, 1);
    step(); idle();
    repeat (2) step();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
